// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the multi-cycle multiply/divide unit: pulses start, stalls the
// front end until the unit answers (or times out), then presents one valid result cycle.
module multdiv_sequencer #(
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DXIR,
  input  logic        dx_valid,
  input  logic        kill,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        status_we,
  output logic [31:0] status_val
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              exc_q, exc_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       status_q, status_d;

  logic is_mul, is_div;
  logic unused_dxir;

  assign is_mul = dx_valid && (DXIR[31:27] == 5'd0) && (DXIR[6:2] == 5'd6);
  assign is_div = dx_valid && (DXIR[31:27] == 5'd0) && (DXIR[6:2] == 5'd7);
  assign unused_dxir = ^{DXIR[26:7], DXIR[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_div_d     = is_div_q;
    exc_d        = exc_q;
    result_d     = result_q;
    status_d     = status_q;
    ctrl_mult    = 1'b0;
    ctrl_div     = 1'b0;
    stall        = 1'b0;
    result_valid = 1'b0;
    status_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((is_mul || is_div) && !kill) begin
          ctrl_mult = is_mul;
          ctrl_div  = is_div;
          stall     = 1'b1;
          is_div_d  = is_div;
          exc_d     = 1'b0;
          cnt_d     = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        stall = !kill;
        cnt_d = cnt_q + CntOne;
        if (kill) begin
          state_d = StIdle;
        end else if (md_ready) begin
          // A ready response always beats a timeout landing in the same cycle.
          result_d = md_exception ? 32'd0 : md_result;
          exc_d    = md_exception;
          if (md_exception) status_d = is_div_q ? 32'd5 : 32'd4;
          state_d  = StDone;
        end else if (cnt_q == CntLast) begin
          result_d = 32'd0;
          status_d = 32'd6;
          exc_d    = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        result_valid = !kill;
        status_we    = !kill && exc_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
      result_q <= 32'd0;
      status_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      exc_q    <= exc_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign result     = result_q;
  assign status_val = status_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboarded bench for multdiv_sequencer: directed ops push expected results, a negedge
// monitor pops and compares whenever result_valid is presented.
module tb_multdiv_sequencer;

  localparam logic [31:0] Mul = 32'h0000_0018;
  localparam logic [31:0] Div = 32'h0000_001C;
  localparam logic [31:0] Add = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset, dx_valid, kill, md_ready, md_exception;
  logic [31:0] DXIR, md_result;
  logic        ctrl_mult, ctrl_div, stall, result_valid, status_we;
  logic [31:0] result, status_val;

  typedef struct packed {
    logic [31:0] res;
    logic        we;
    logic [31:0] sv;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  multdiv_sequencer #(.MAX_CYCLES(40), .CNT_W(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .DXIR        (DXIR),
    .dx_valid    (dx_valid),
    .kill        (kill),
    .md_ready    (md_ready),
    .md_exception(md_exception),
    .md_result   (md_result),
    .ctrl_mult   (ctrl_mult),
    .ctrl_div    (ctrl_div),
    .stall       (stall),
    .result_valid(result_valid),
    .result      (result),
    .status_we   (status_we),
    .status_val  (status_val)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset && result_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_status_we", {31'd0, status_we}, {31'd0, e.we});
        if (e.we) chk("sb_status_val", status_val, e.sv);
      end
    end
  end

  // One full op: start pulse, k BUSY cycles with md_ready on the k-th, then DONE.
  task automatic run_op(input logic [31:0] ir, input int k, input logic exc,
                        input logic [31:0] res);
    exp_t e;
    DXIR = ir;
    dx_valid = 1'b1;
    @(negedge clock);
    chk("start_mult", {31'd0, ctrl_mult}, {31'd0, ir == Mul});
    chk("start_div", {31'd0, ctrl_div}, {31'd0, ir == Div});
    chk("start_stall", {31'd0, stall}, 32'd1);
    cyc();
    for (int i = 1; i < k; i++) begin
      @(negedge clock);
      chk("busy_stall", {31'd0, stall}, 32'd1);
      chk("busy_no_pulse", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
      cyc();
    end
    md_ready = 1'b1;
    md_exception = exc;
    md_result = res;
    e.res = exc ? 32'd0 : res;
    e.we  = exc;
    e.sv  = (ir == Div) ? 32'd5 : 32'd4;
    sb_q.push_back(e);
    @(negedge clock);
    chk("ready_stall", {31'd0, stall}, 32'd1);
    cyc();
    md_ready = 1'b0;
    md_exception = 1'b0;
    md_result = 32'd0;
    @(negedge clock);
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_no_restart", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    reset = 1'b1; DXIR = Add; dx_valid = 1'b0; kill = 1'b0;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    cyc();
    cyc();
    @(negedge clock);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_outputs", {28'd0, ctrl_mult, ctrl_div, result_valid, status_we}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_status_val", status_val, 32'd0);
    cyc();
    reset = 1'b0;

    // Basic multiply, ready 5 cycles after start.
    run_op(Mul, 5, 1'b0, 32'h0000_0042);
    dx_valid = 1'b0;
    cyc();

    run_op(Div, 3, 1'b1, 32'hDEAD_BEEF);
    dx_valid = 1'b0;
    cyc();
    run_op(Mul, 2, 1'b1, 32'h1111_1111);
    dx_valid = 1'b0;
    cyc();

    // Back-to-back: div enters D/X the cycle right after the mul's DONE.
    run_op(Mul, 2, 1'b0, 32'h0000_1234);
    run_op(Div, 1, 1'b0, 32'h0000_0007);
    dx_valid = 1'b0;
    cyc();

    // Timeout: md_ready never comes.
    e.res = 32'd0; e.we = 1'b1; e.sv = 32'd6;
    sb_q.push_back(e);
    DXIR = Div; dx_valid = 1'b1;
    @(negedge clock);
    chk("to_start_div", {31'd0, ctrl_div}, 32'd1);
    cyc();
    n = 0;
    while (n < 60) begin
      @(negedge clock);
      if (!stall) break;
      n++;
      cyc();
    end
    chk("timeout_busy_cycles", n, 32'd40);
    cyc();
    dx_valid = 1'b0;
    cyc();

    // Kill in BUSY cycle 3, then a late md_ready.
    DXIR = Mul; dx_valid = 1'b1;
    cyc();
    cyc();
    cyc();
    kill = 1'b1;
    @(negedge clock);
    chk("kill_stall", {31'd0, stall}, 32'd0);
    cyc();
    kill = 1'b0; dx_valid = 1'b0;
    cyc();
    md_ready = 1'b1; md_result = 32'h0000_0099;
    @(negedge clock);
    chk("kill_late_ready", {29'd0, ctrl_mult, ctrl_div, stall}, 32'd0);
    cyc();
    md_ready = 1'b0;
    @(negedge clock);
    chk("kill_no_result", {31'd0, result_valid}, 32'd0);
    cyc();

    // Reset mid-operation, then a stale md_ready.
    DXIR = Mul; dx_valid = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; dx_valid = 1'b0;
    @(negedge clock);
    chk("rst_busy_outputs", {28'd0, ctrl_mult, ctrl_div, stall, result_valid}, 32'd0);
    chk("rst_busy_result", result, 32'd0);
    md_ready = 1'b1; md_result = 32'h0000_0055;
    cyc();
    md_ready = 1'b0;
    @(negedge clock);
    chk("rst_stale_ready", {30'd0, stall, result_valid}, 32'd0);
    cyc();

    // Non-md instructions.
    DXIR = Add; dx_valid = 1'b1;
    @(negedge clock);
    chk("add_no_action", {29'd0, ctrl_mult, ctrl_div, stall}, 32'd0);
    cyc();
    DXIR = Mul; dx_valid = 1'b0;
    @(negedge clock);
    chk("bubble_no_action", {29'd0, ctrl_mult, ctrl_div, stall}, 32'd0);
    cyc();
    cyc();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
